partition_arbiter: RTL and testbench
====================================

PARTITION_ARBITER -- requirements
Module: partition_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter REGION_WIDTH, default 64, region/mask width; matches partition core.
REQ-003 SHALL have parameter MU_WIDTH, default 32, width of μ values.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait for core_op_done after issue.
REQ-005 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester request pending.
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot accept pulse.
REQ-009 SHALL have port req_op  in  NUM_REQ*8  per-requester opcode.
REQ-010 SHALL have port req_region  in  NUM_REQ*REGION_WIDTH  per-requester PNEW region or PSPLIT mask.
REQ-011 SHALL have port req_arg_a / req_arg_b  in  NUM_REQ*8 each  module ids (PSPLIT id in a; PMERGE m1 in a, m2 in b).
REQ-012 SHALL have port resp_valid  out  NUM_REQ  one-hot completion pulse.
REQ-013 SHALL have port resp_status  out  2  OK=0, ILLEGAL=1, BUDGET=2, TIMEOUT=3.
REQ-014 SHALL have port resp_module_id  out  8  core result id; 0 unless status OK.
REQ-015 SHALL have core-side outputs core_op (8), core_op_valid (1), core_pnew_region, core_psplit_mask (REGION_WIDTH each), core_psplit_module_id, core_pmerge_m1, core_pmerge_m2 (8 each).
REQ-016 SHALL have core-side inputs core_op_done (1), core_result_module_id (8), core_mu_cost (MU_WIDTH).
REQ-017 SHALL have port mu_budget  in  MU_WIDTH  μ ceiling (used only when the macro in REQ-033 is defined).
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with ISSUE -> RESP directly on reject.
REQ-020 In IDLE with any req_valid set, SHALL grant round-robin, starting the search at (last grant + 1) mod NUM_REQ.
REQ-021 On grant, SHALL pulse req_ready[i] for one cycle, latch that requester's payload, and enter ISSUE.
REQ-022 SHALL leave every other requester's req_ready low, so its request is held and not accepted.
REQ-023 In ISSUE, SHALL reject opcodes other than PNEW 0x00, PSPLIT 0x01, PMERGE 0x02 and MDLACC 0x05 with status ILLEGAL, without issuing to the core.
REQ-024 In ISSUE with a legal opcode, SHALL drive core_op_valid high for exactly one cycle, then enter WAIT.
REQ-025 SHALL hold all core_* payload outputs stable from ISSUE until leaving WAIT.
REQ-026 SHALL drive all core_* payload outputs to 0 in IDLE.
REQ-027 In WAIT, SHALL latch core_result_module_id with status OK when core_op_done is sampled high, then enter RESP.
REQ-028 In WAIT, SHALL use a counter cleared on WAIT entry; on reaching TIMEOUT_CYCLES without done, it SHALL set status TIMEOUT and enter RESP.
REQ-029 If done and timeout coincide, done SHALL win.
REQ-030 In RESP, SHALL pulse resp_valid[granted] for one cycle with status and id; resp_status and resp_module_id SHALL hold until the next RESP.
REQ-031 SHALL ignore core_op_done outside WAIT.
REQ-032 With an ideal core (done 3 cycles after op_valid), accept-to-resp_valid latency SHALL be 5 cycles.

Configuration
REQ-033 With PART_ARB_MU_BUDGET_EN defined, ISSUE SHALL reject legal ops with status BUDGET when core_mu_cost >= mu_budget; without it, mu_budget SHALL be unused and BUDGET never produced.

Reset
REQ-034 While rst is high, SHALL force FSM=IDLE, the round-robin pointer to NUM_REQ-1 (requester 0 granted first), and all outputs, counters and latches to 0.
REQ-035 Reset mid-operation SHALL drop the transaction with no resp_valid; the arbiter does not reset the core.

Structure
REQ-036 Opcode constants, status codes and state encodings SHALL live in shared package partition_pkg.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer -> one-hot grant).

Verification
REQ-038 Single PNEW from req 0 (region 0xF0) with a core model: resp_valid[0] 5 cycles after req_ready[0], status 0, id 0.
REQ-039 All four requesters valid at once: grants in order 0,1,2,3, then 0 again on re-request; no two simultaneous req_ready bits.
REQ-040 Opcode 0x0E from req 2: no core_op_valid, resp_valid[2] with status 1, id 0.
REQ-041 Core model never asserts done: status 3 exactly TIMEOUT_CYCLES(16) cycles after WAIT entry; done arriving on that same cycle gives status 0.
REQ-042 Budget build, mu_budget=10, core_mu_cost=10, PMERGE: status 2, no core_op_valid; non-budget build: status 0.
REQ-043 rst asserted during WAIT: outputs 0 immediately, no resp_valid, next grant goes to req 0.

Source files
------------

// File: rtl/partition_pkg.sv
// Shared opcode, status and FSM encodings for the partition arbiter and its requesters.
package partition_pkg;

  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;
  localparam logic [7:0] OP_MDLACC = 8'h05;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ILLEGAL = 2'd1,
    STAT_BUDGET  = 2'd2,
    STAT_TIMEOUT = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return op inside {OP_PNEW, OP_PSPLIT, OP_PMERGE, OP_MDLACC};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches upward from (last grant + 1) mod NUM_REQ, returns a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!o_any && i_req[(int'(i_last) + off) % NUM_REQ]) begin
        o_any                                     = 1'b1;
        o_grant[(int'(i_last) + off) % NUM_REQ]   = 1'b1;
        o_grant_idx = IDX_W'((int'(i_last) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/partition_arbiter.sv
// Arbitrates NUM_REQ requesters onto one partition core: grant, issue, wait for done, respond.
// Define PART_ARB_MU_BUDGET_EN to reject legal ops whose core_mu_cost reaches mu_budget.
module partition_arbiter
  import partition_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int REGION_WIDTH   = 64,
  parameter int MU_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*8-1:0]         req_op,
  input  logic [NUM_REQ*REGION_WIDTH-1:0] req_region,
  input  logic [NUM_REQ*8-1:0]         req_arg_a,
  input  logic [NUM_REQ*8-1:0]         req_arg_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [1:0]                   resp_status,
  output logic [7:0]                   resp_module_id,
  output logic [7:0]                   core_op,
  output logic                         core_op_valid,
  output logic [REGION_WIDTH-1:0]      core_pnew_region,
  output logic [REGION_WIDTH-1:0]      core_psplit_mask,
  output logic [7:0]                   core_psplit_module_id,
  output logic [7:0]                   core_pmerge_m1,
  output logic [7:0]                   core_pmerge_m2,
  input  logic                         core_op_done,
  input  logic [7:0]                   core_result_module_id,
  input  logic [MU_WIDTH-1:0]          core_mu_cost,
  input  logic [MU_WIDTH-1:0]          mu_budget,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_any;
  logic [7:0]              w_op;
  logic [7:0]              w_arg_a;
  logic [7:0]              w_arg_b;
  logic [REGION_WIDTH-1:0] w_region;
  logic                    w_over_budget;
  logic                    w_finish;
  status_t                 w_fin_status;
  logic [7:0]              w_fin_id;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_last;
  logic [NUM_REQ-1:0]      r_grant;
  logic [7:0]              r_op;
  logic [CNT_W-1:0]        r_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req       (req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_op     = req_op[int'(w_grant_idx)*8 +: 8];
  assign w_arg_a  = req_arg_a[int'(w_grant_idx)*8 +: 8];
  assign w_arg_b  = req_arg_b[int'(w_grant_idx)*8 +: 8];
  assign w_region = req_region[int'(w_grant_idx)*REGION_WIDTH +: REGION_WIDTH];
  assign busy     = (r_state != ST_IDLE);

`ifdef PART_ARB_MU_BUDGET_EN
  assign w_over_budget = (core_mu_cost >= mu_budget);
`else
  logic w_unused_mu;
  assign w_unused_mu   = ^{core_mu_cost, mu_budget};
  assign w_over_budget = 1'b0;
`endif

  // Decides whether this cycle ends the transaction and with which status.
  always_comb begin
    w_finish     = 1'b0;
    w_fin_status = STAT_OK;
    w_fin_id     = '0;
    case (r_state)
      ST_ISSUE: begin
        if (!is_legal_op(r_op)) begin
          w_finish     = 1'b1;
          w_fin_status = STAT_ILLEGAL;
        end else if (w_over_budget) begin
          w_finish     = 1'b1;
          w_fin_status = STAT_BUDGET;
        end
      end
      ST_WAIT: begin
        if (core_op_done) begin
          w_finish     = 1'b1;
          w_fin_id     = core_result_module_id;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_finish     = 1'b1;
          w_fin_status = STAT_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state               <= ST_IDLE;
      r_last                <= IDX_W'(NUM_REQ - 1);
      r_grant               <= '0;
      r_op                  <= '0;
      r_cnt                 <= '0;
      req_ready             <= '0;
      resp_valid            <= '0;
      resp_status           <= '0;
      resp_module_id        <= '0;
      core_op               <= '0;
      core_op_valid         <= 1'b0;
      core_pnew_region      <= '0;
      core_psplit_mask      <= '0;
      core_psplit_module_id <= '0;
      core_pmerge_m1        <= '0;
      core_pmerge_m2        <= '0;
    end else begin
      req_ready     <= '0;
      resp_valid    <= '0;
      core_op_valid <= 1'b0;
      if (w_finish) begin
        resp_valid            <= r_grant;
        resp_status           <= w_fin_status;
        resp_module_id        <= w_fin_id;
        core_op               <= '0;
        core_pnew_region      <= '0;
        core_psplit_mask      <= '0;
        core_psplit_module_id <= '0;
        core_pmerge_m1        <= '0;
        core_pmerge_m2        <= '0;
        r_state               <= ST_RESP;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any) begin
              req_ready <= w_grant;
              r_grant   <= w_grant;
              r_last    <= w_grant_idx;
              r_op      <= w_op;
              // Only the fields the opcode uses reach the core; illegal ops leave it all-zero.
              if (is_legal_op(w_op)) begin
                core_op               <= w_op;
                core_pnew_region      <= (w_op == OP_PNEW)   ? w_region : '0;
                core_psplit_mask      <= (w_op == OP_PSPLIT) ? w_region : '0;
                core_psplit_module_id <= (w_op == OP_PSPLIT) ? w_arg_a  : '0;
                core_pmerge_m1        <= (w_op == OP_PMERGE) ? w_arg_a  : '0;
                core_pmerge_m2        <= (w_op == OP_PMERGE) ? w_arg_b  : '0;
              end
              r_state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            core_op_valid <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ST_WAIT;
          end
          ST_WAIT:  r_cnt   <= r_cnt + CNT_W'(1);
          ST_RESP:  r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_partition_arbiter.sv
// Scoreboard bench for partition_arbiter: directed requests, a delay-programmable core model and a response monitor.
module tb_partition_arbiter;

  localparam int NUM = 4;
  localparam int RW  = 64;
  localparam int MW  = 32;
  localparam int TO  = 16;

  logic               clk;
  logic               rst;
  logic [NUM-1:0]     req_valid;
  logic [NUM-1:0]     req_ready;
  logic [NUM*8-1:0]   req_op;
  logic [NUM*RW-1:0]  req_region;
  logic [NUM*8-1:0]   req_arg_a;
  logic [NUM*8-1:0]   req_arg_b;
  logic [NUM-1:0]     resp_valid;
  logic [1:0]         resp_status;
  logic [7:0]         resp_module_id;
  logic [7:0]         core_op;
  logic               core_op_valid;
  logic [RW-1:0]      core_pnew_region;
  logic [RW-1:0]      core_psplit_mask;
  logic [7:0]         core_psplit_module_id;
  logic [7:0]         core_pmerge_m1;
  logic [7:0]         core_pmerge_m2;
  logic               core_op_done;
  logic [7:0]         core_rid;
  logic [MW-1:0]      core_mu_cost;
  logic [MW-1:0]      mu_budget;
  logic               busy;

  partition_arbiter #(
    .NUM_REQ(NUM), .REGION_WIDTH(RW), .MU_WIDTH(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_region(req_region), .req_arg_a(req_arg_a), .req_arg_b(req_arg_b),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_module_id(resp_module_id),
    .core_op(core_op), .core_op_valid(core_op_valid),
    .core_pnew_region(core_pnew_region), .core_psplit_mask(core_psplit_mask),
    .core_psplit_module_id(core_psplit_module_id),
    .core_pmerge_m1(core_pmerge_m1), .core_pmerge_m2(core_pmerge_m2),
    .core_op_done(core_op_done), .core_result_module_id(core_rid),
    .core_mu_cost(core_mu_cost), .mu_budget(mu_budget), .busy(busy)
  );

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic [7:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   gq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready_cyc, opv_cyc, resp_cyc;
  int   opv_count = 0;
  logic [7:0]    rec_op;
  logic [RW-1:0] rec_region;
  logic [7:0]    rec_m1, rec_m2;
  int   core_lat = 3;
  int   cd = 0;
  exp_t m_e;
  int   m_g;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic push_exp(input int idx, input logic [1:0] st, input logic [7:0] id);
    exp_t e;
    e.idx = idx;
    e.st  = st;
    e.id  = id;
    sb_q.push_back(e);
  endtask

  task automatic post(input int i, input logic [7:0] op, input logic [RW-1:0] rg,
                      input logic [7:0] a, input logic [7:0] b);
    req_op[i*8 +: 8]      = op;
    req_region[i*RW +: RW] = rg;
    req_arg_a[i*8 +: 8]   = a;
    req_arg_b[i*8 +: 8]   = b;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int n = 0;
    while ((sb_q.size() != 0 || gq.size() != 0) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    check(nm, 64'(sb_q.size() + gq.size()), 64'd0);
    @(negedge clk);
  endtask

  // Requesters withdraw their request once accepted.
  always @(negedge clk) begin
    for (int i = 0; i < NUM; i++)
      if (req_ready[i]) req_valid[i] = 1'b0;
  end

  // Core model: done pulses core_lat cycles after op_valid; core_lat == 0 means never.
  always @(negedge clk) begin
    core_op_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) core_op_done = 1'b1;
    end
    if (core_op_valid && core_lat > 0) cd = core_lat;
  end

  // Monitor: grant order, core issue capture and response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        ready_cyc = cyc;
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        if (gq.size() == 0) check("ready_unexpected", 64'(req_ready), 64'd0);
        else begin
          m_g = gq.pop_front();
          check("grant_order", 64'(req_ready), 64'(4'(1) << m_g));
        end
      end
      if (core_op_valid) begin
        opv_count++;
        opv_cyc    = cyc;
        rec_op     = core_op;
        rec_region = core_pnew_region;
        rec_m1     = core_pmerge_m1;
        rec_m2     = core_pmerge_m2;
      end
      if (resp_valid != '0) begin
        resp_cyc = cyc;
        if (sb_q.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          m_e = sb_q.pop_front();
          check("resp_port", 64'(resp_valid), 64'(4'(1) << m_e.idx));
          check("resp_status", 64'(resp_status), 64'(m_e.st));
          check("resp_id", 64'(resp_module_id), 64'(m_e.id));
        end
      end
    end
  end

  int opv0;
  int exp_opv;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_region = '0; req_arg_a = '0; req_arg_b = '0;
    core_op_done = 1'b0; core_rid = '0; core_mu_cost = '0; mu_budget = 32'd10;
    rec_op = '1; rec_region = '0; rec_m1 = '0; rec_m2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_core_op_valid", 64'(core_op_valid), 64'd0);
    check("rst_resp_status", 64'(resp_status), 64'd0);
    check("rst_core_region", core_pnew_region, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single PNEW from requester 0, ideal core.
    core_rid = 8'h00; core_lat = 3;
    gq.push_back(0); push_exp(0, 2'd0, 8'h00);
    post(0, 8'h00, 64'hF0, 8'h0, 8'h0);
    wait_drain(40, "pnew_drain");
    check("pnew_latency", 64'(resp_cyc - ready_cyc), 64'd5);
    check("pnew_core_op", 64'(rec_op), 64'h00);
    check("pnew_core_region", rec_region, 64'hF0);
    check("idle_busy", 64'(busy), 64'd0);

    // Illegal opcode from requester 2.
    opv0 = opv_count;
    gq.push_back(2); push_exp(2, 2'd1, 8'h00);
    post(2, 8'h0E, 64'h1, 8'h3, 8'h4);
    wait_drain(40, "illegal_drain");
    check("illegal_no_issue", 64'(opv_count - opv0), 64'd0);

    // Budget boundary: cost equal to budget.
    opv0 = opv_count;
    core_rid = 8'h33; core_mu_cost = 32'd10; mu_budget = 32'd10;
    gq.push_back(3);
`ifdef PART_ARB_MU_BUDGET_EN
    push_exp(3, 2'd2, 8'h00);
    exp_opv = 0;
`else
    push_exp(3, 2'd0, 8'h33);
    exp_opv = 1;
`endif
    post(3, 8'h02, 64'h0, 8'h05, 8'h06);
    wait_drain(40, "budget_drain");
    check("budget_issue_count", 64'(opv_count - opv0), 64'(exp_opv));
`ifndef PART_ARB_MU_BUDGET_EN
    check("pmerge_m1", 64'(rec_m1), 64'h05);
    check("pmerge_m2", 64'(rec_m2), 64'h06);
`endif
    core_mu_cost = '0;

    // All four at once: round-robin from 0, then 0 again.
    core_rid = 8'h40;
    for (int i = 0; i < NUM; i++) begin
      gq.push_back(i);
      push_exp(i, 2'd0, 8'h40);
    end
    post(0, 8'h00, 64'h1, 8'h0, 8'h0);
    post(1, 8'h01, 64'hFF00, 8'h07, 8'h0);
    post(2, 8'h02, 64'h0, 8'h01, 8'h02);
    post(3, 8'h05, 64'h0, 8'h0, 8'h0);
    wait_drain(200, "all4_drain");
    repeat (3) @(negedge clk);
    check("hold_status", 64'(resp_status), 64'd0);
    check("hold_id", 64'(resp_module_id), 64'h40);
    core_rid = 8'h41;
    gq.push_back(0); push_exp(0, 2'd0, 8'h41);
    post(0, 8'h05, 64'h0, 8'h0, 8'h0);
    wait_drain(40, "rerequest_drain");

    // Timeout, done on the last WAIT cycle, done one cycle late.
    core_lat = 0; core_rid = 8'h55;
    gq.push_back(1); push_exp(1, 2'd3, 8'h00);
    post(1, 8'h01, 64'h3C, 8'h09, 8'h0);
    wait_drain(60, "timeout_drain");
    check("timeout_latency", 64'(resp_cyc - opv_cyc), 64'd16);
    core_lat = 15; core_rid = 8'h2A;
    gq.push_back(1); push_exp(1, 2'd0, 8'h2A);
    post(1, 8'h01, 64'h3C, 8'h09, 8'h0);
    wait_drain(60, "done_at_limit_drain");
    check("done_at_limit_latency", 64'(resp_cyc - opv_cyc), 64'd16);
    core_lat = 16;
    gq.push_back(1); push_exp(1, 2'd3, 8'h00);
    post(1, 8'h01, 64'h3C, 8'h09, 8'h0);
    wait_drain(60, "late_done_drain");
    repeat (3) @(negedge clk);

    // Reset in WAIT drops the transaction and restarts the pointer.
    core_lat = 0;
    opv0 = opv_count;
    gq.push_back(1);
    post(1, 8'h00, 64'h3, 8'h0, 8'h0);
    for (int i = 0; i < 20 && opv_count == opv0; i++) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_core_op", 64'(core_op), 64'd0);
    check("midrst_core_region", core_pnew_region, 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    core_lat = 3; core_rid = 8'h66;
    gq.push_back(0); gq.push_back(3);
    push_exp(0, 2'd0, 8'h66); push_exp(3, 2'd0, 8'h66);
    post(3, 8'h00, 64'h8, 8'h0, 8'h0);
    post(0, 8'h00, 64'h4, 8'h0, 8'h0);
    wait_drain(80, "post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
